// File: rtl/alarm_pkg.sv
// rtl/alarm_pkg.sv - shared state encodings, BCD time type and validity check for the alarm scheduler
package alarm_pkg;

  localparam logic [1:0] STATE_IDLE   = 2'd0;
  localparam logic [1:0] STATE_RING   = 2'd1;
  localparam logic [1:0] STATE_SNOOZE = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE   = STATE_IDLE,
    ST_RING   = STATE_RING,
    ST_SNOOZE = STATE_SNOOZE
  } sched_state_t;

  typedef struct packed {
    logic [3:0] hour_dec;
    logic [3:0] hour_one;
    logic [3:0] min_dec;
    logic [3:0] min_one;
  } bcd_time_t;

  // Legal wall-clock time 00:00..23:59 with every digit in 0..9
  function automatic logic bcd_time_valid(input bcd_time_t t);
    logic w_digits_ok;
    logic w_hours_ok;
    w_digits_ok = (t.hour_dec <= 4'd9) && (t.hour_one <= 4'd9) &&
                  (t.min_dec <= 4'd5) && (t.min_one <= 4'd9);
    w_hours_ok  = (t.hour_dec < 4'd2) || ((t.hour_dec == 4'd2) && (t.hour_one <= 4'd3));
    return w_digits_ok && w_hours_ok;
  endfunction

endpackage

// File: rtl/alarm_slot_match.sv
// rtl/alarm_slot_match.sv - one alarm slot: time/enable register, comparator and pending bit
// ALARM_SCHED_ONESHOT_EN: enable clears on grant.
module alarm_slot_match
  import alarm_pkg::*;
(
  input  logic      i_clk,
  input  logic      i_rst,
  input  logic      i_min_evt,
  input  bcd_time_t i_now,
  input  logic      i_wr,
  input  bcd_time_t i_wr_time,
  input  logic      i_wr_en,
  input  logic      i_grant,
  output logic      o_pending
);

  bcd_time_t r_time;
  logic      r_en;
  logic      r_pend;
  logic      w_hit;

  // Compare against the pre-write contents so a same-cycle write never affects this match
  assign w_hit     = i_min_evt && r_en && (r_time == i_now);
  assign o_pending = r_pend;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_time <= '0;
      r_en   <= 1'b0;
      r_pend <= 1'b0;
    end else begin
      if (i_wr) begin
        r_time <= i_wr_time;
        r_en   <= i_wr_en;
      end
`ifdef ALARM_SCHED_ONESHOT_EN
      else if (i_grant) begin
        r_en <= 1'b0;
      end
`endif
      if (i_wr && !i_wr_en) begin
        r_pend <= 1'b0;
      end else begin
        r_pend <= (r_pend && !i_grant) || w_hit;
      end
    end
  end

endmodule

// File: rtl/alarm_scheduler.sv
// rtl/alarm_scheduler.sv - multi-slot BCD alarm scheduler: match, lowest-index arbitration, ring/snooze FSM
// ALARM_SCHED_ONESHOT_EN (see alarm_slot_match) makes alarms one-shot.
module alarm_scheduler
  import alarm_pkg::*;
#(
  parameter int N_SLOTS    = 4,
  parameter int RING_MIN   = 5,
  parameter int SNOOZE_MIN = 9,
  parameter int MAX_SNOOZE = 3,
  localparam int SLOT_W    = $clog2(N_SLOTS)
) (
  input  logic                pclk_i,
  input  logic                preset_i,
  input  logic [15:0]         now_i,
  input  logic                cfg_we_i,
  input  logic [SLOT_W-1:0]   cfg_slot_i,
  input  logic [15:0]         cfg_time_i,
  input  logic                cfg_en_i,
  input  logic                snooze_i,
  input  logic                stop_i,
  output logic                ring_o,
  output logic [1:0]          state_o,
  output logic [SLOT_W-1:0]   active_slot_o,
  output logic [N_SLOTS-1:0]  pending_o,
  output logic                missed_o,
  output logic                cfg_err_o
);

  localparam logic [3:0] RING_INIT = 4'(RING_MIN);
  localparam logic [3:0] SNZ_INIT  = 4'(SNOOZE_MIN);
  localparam logic [2:0] SNZ_LIMIT = 3'(MAX_SNOOZE);

  sched_state_t        r_state, w_state_n;
  logic [15:0]         r_now_q;
  logic                r_first_q;
  logic                r_ring, w_ring_n;
  logic [SLOT_W-1:0]   r_active, w_active_n;
  logic [3:0]          r_ring_cnt, w_ring_cnt_n;
  logic [3:0]          r_snz_cnt, w_snz_cnt_n;
  logic [2:0]          r_snz_used, w_snz_used_n;
  logic                r_missed, w_missed_n;
  logic                r_cfg_err;

  logic                w_min_evt;
  logic                w_cfg_ok;
  logic                w_wr_ok;
  logic [N_SLOTS-1:0]  w_pending;
  logic [N_SLOTS-1:0]  w_grant_vec;
  logic                w_grant;
  logic [SLOT_W-1:0]   w_idx;

  assign w_min_evt = (now_i != r_now_q) && !r_first_q;
  assign w_cfg_ok  = bcd_time_valid(cfg_time_i);
  assign w_wr_ok   = cfg_we_i && w_cfg_ok;

  genvar g;
  generate
    for (g = 0; g < N_SLOTS; g++) begin : g_slot
      alarm_slot_match u_slot (
        .i_clk     (pclk_i),
        .i_rst     (preset_i),
        .i_min_evt (w_min_evt),
        .i_now     (now_i),
        .i_wr      (w_wr_ok && (cfg_slot_i == SLOT_W'(g))),
        .i_wr_time (cfg_time_i),
        .i_wr_en   (cfg_en_i),
        .i_grant   (w_grant_vec[g]),
        .o_pending (w_pending[g])
      );
    end
  endgenerate

  // Lowest pending index wins
  always_comb begin
    w_idx = '0;
    for (int i = N_SLOTS - 1; i >= 0; i--) begin
      if (w_pending[i]) w_idx = SLOT_W'(i);
    end
  end

  always_comb begin
    w_state_n    = r_state;
    w_ring_n     = r_ring;
    w_active_n   = r_active;
    w_ring_cnt_n = r_ring_cnt;
    w_snz_cnt_n  = r_snz_cnt;
    w_snz_used_n = r_snz_used;
    w_missed_n   = 1'b0;
    w_grant      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (|w_pending) begin
          w_grant      = 1'b1;
          w_active_n   = w_idx;
          w_ring_cnt_n = RING_INIT;
          w_snz_used_n = '0;
          w_ring_n     = 1'b1;
          w_state_n    = ST_RING;
        end
      end
      ST_RING: begin
        if (stop_i) begin
          w_ring_n  = 1'b0;
          w_state_n = ST_IDLE;
        end else if (snooze_i && (r_snz_used < SNZ_LIMIT)) begin
          w_snz_cnt_n  = SNZ_INIT;
          w_snz_used_n = r_snz_used + 3'd1;
          w_ring_n     = 1'b0;
          w_state_n    = ST_SNOOZE;
        end else if (w_min_evt) begin
          if (r_ring_cnt == 4'd1) begin
            w_ring_cnt_n = '0;
            w_ring_n     = 1'b0;
            w_missed_n   = 1'b1;
            w_state_n    = ST_IDLE;
          end else begin
            w_ring_cnt_n = r_ring_cnt - 4'd1;
          end
        end
      end
      ST_SNOOZE: begin
        if (stop_i) begin
          w_ring_n  = 1'b0;
          w_state_n = ST_IDLE;
        end else if (w_min_evt) begin
          if (r_snz_cnt == 4'd1) begin
            w_snz_cnt_n  = '0;
            w_ring_cnt_n = RING_INIT;
            w_ring_n     = 1'b1;
            w_state_n    = ST_RING;
          end else begin
            w_snz_cnt_n = r_snz_cnt - 4'd1;
          end
        end
      end
      default: begin
        w_ring_n  = 1'b0;
        w_state_n = ST_IDLE;
      end
    endcase
  end

  assign w_grant_vec = w_grant ? (N_SLOTS'(1) << w_idx) : '0;

  always_ff @(posedge pclk_i) begin
    if (preset_i) begin
      r_state    <= ST_IDLE;
      r_now_q    <= '0;
      r_first_q  <= 1'b1;
      r_ring     <= 1'b0;
      r_active   <= '0;
      r_ring_cnt <= '0;
      r_snz_cnt  <= '0;
      r_snz_used <= '0;
      r_missed   <= 1'b0;
      r_cfg_err  <= 1'b0;
    end else begin
      r_state    <= w_state_n;
      r_now_q    <= now_i;
      r_first_q  <= 1'b0;
      r_ring     <= w_ring_n;
      r_active   <= w_active_n;
      r_ring_cnt <= w_ring_cnt_n;
      r_snz_cnt  <= w_snz_cnt_n;
      r_snz_used <= w_snz_used_n;
      r_missed   <= w_missed_n;
      r_cfg_err  <= cfg_we_i && !w_cfg_ok;
    end
  end

  assign ring_o        = r_ring;
  assign state_o       = r_state;
  assign active_slot_o = r_active;
  assign pending_o     = w_pending;
  assign missed_o      = r_missed;
  assign cfg_err_o     = r_cfg_err;

endmodule

// File: tb/tb_alarm_scheduler.sv
// tb/tb_alarm_scheduler.sv - scoreboard bench for alarm_scheduler: directed stimulus, cycle-stamped expectations
module tb_alarm_scheduler;

  typedef enum int {K_RING, K_STATE, K_PEND, K_ACT, K_MISSED, K_ERR} kind_t;
  typedef struct {
    int          cyc;
    kind_t       kind;
    logic [15:0] val;
  } exp_t;

  logic        clk = 1'b0;
  logic        preset = 1'b1;
  logic [15:0] now = 16'h1200;
  logic        cfg_we = 1'b0;
  logic [1:0]  cfg_slot = 2'd0;
  logic [15:0] cfg_time = 16'h0000;
  logic        cfg_en = 1'b0;
  logic        snooze = 1'b0;
  logic        stop = 1'b0;
  logic        ring;
  logic [1:0]  state;
  logic [1:0]  active;
  logic [3:0]  pending;
  logic        missed;
  logic        cfg_err;

  int   cyc = 0;
  int   n_vec = 0;
  int   n_bad = 0;
  int   n_missed_seen = 0;
  int   n_err_seen = 0;
  exp_t sb[$];

  alarm_scheduler dut (
    .pclk_i        (clk),
    .preset_i      (preset),
    .now_i         (now),
    .cfg_we_i      (cfg_we),
    .cfg_slot_i    (cfg_slot),
    .cfg_time_i    (cfg_time),
    .cfg_en_i      (cfg_en),
    .snooze_i      (snooze),
    .stop_i        (stop),
    .ring_o        (ring),
    .state_o       (state),
    .active_slot_o (active),
    .pending_o     (pending),
    .missed_o      (missed),
    .cfg_err_o     (cfg_err)
  );

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic string kname(input kind_t k);
    case (k)
      K_RING:   return "ring_o";
      K_STATE:  return "state_o";
      K_PEND:   return "pending_o";
      K_ACT:    return "active_slot_o";
      K_MISSED: return "missed_o";
      default:  return "cfg_err_o";
    endcase
  endfunction

  function automatic logic [15:0] observe(input kind_t k);
    case (k)
      K_RING:   return {15'b0, ring};
      K_STATE:  return {14'b0, state};
      K_PEND:   return {12'b0, pending};
      K_ACT:    return {14'b0, active};
      K_MISSED: return {15'b0, missed};
      default:  return {15'b0, cfg_err};
    endcase
  endfunction

  // Monitor: pops every expectation stamped for the current cycle
  initial begin
    exp_t        e;
    logic [15:0] got;
    forever begin
      @(negedge clk);
      if (missed)  n_missed_seen++;
      if (cfg_err) n_err_seen++;
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e   = sb.pop_front();
        got = observe(e.kind);
        n_vec++;
        if (e.cyc != cyc || got !== e.val) begin
          n_bad++;
          $display("FAIL %s @cyc %0d (checked at %0d): got %h, expected %h",
                   kname(e.kind), e.cyc, cyc, got, e.val);
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_at(input kind_t k, input logic [15:0] v, input int dt);
    exp_t e;
    e.cyc  = cyc + dt;
    e.kind = k;
    e.val  = v;
    sb.push_back(e);
  endtask

  task automatic cfg_write(input logic [1:0] slot, input logic [15:0] t, input logic en, input logic err);
    cfg_we   = 1'b1;
    cfg_slot = slot;
    cfg_time = t;
    cfg_en   = en;
    expect_at(K_ERR, {15'b0, err}, 1);
    expect_at(K_ERR, 16'h0, 2);
    step(1);
    cfg_we = 1'b0;
    step(1);
  endtask

  task automatic snooze_round(input logic [15:0] base);
    snooze = 1'b1;
    expect_at(K_RING, 16'h0, 1);
    expect_at(K_STATE, 16'h2, 1);
    step(1);
    snooze = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      now = base + 16'(i);
      expect_at(K_RING, (i == 9) ? 16'h1 : 16'h0, 1);
      expect_at(K_STATE, (i == 9) ? 16'h1 : 16'h2, 1);
      step(1);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got no $finish, expected completion");
    $fatal(1);
  end

  initial begin
    step(2);
    preset = 1'b0;
    expect_at(K_RING, 16'h0, 0);
    expect_at(K_STATE, 16'h0, 0);
    expect_at(K_PEND, 16'h0, 0);
    expect_at(K_ACT, 16'h0, 0);
    step(1);

    // Single slot: pending one cycle after the minute change, ring one cycle later
    cfg_write(2'd0, 16'h0730, 1'b1, 1'b0);
    now = 16'h0729;
    step(1);
    now = 16'h0730;
    expect_at(K_PEND, 16'h1, 1);
    expect_at(K_RING, 16'h0, 1);
    expect_at(K_RING, 16'h1, 2);
    expect_at(K_ACT, 16'h0, 2);
    expect_at(K_STATE, 16'h1, 2);
    expect_at(K_PEND, 16'h0, 2);
    step(3);
    stop = 1'b1;
    expect_at(K_RING, 16'h0, 1);
    expect_at(K_STATE, 16'h0, 1);
    step(1);
    stop = 1'b0;
    step(1);

    // Simultaneous hit on slots 1 and 2: lowest first, the other after stop
    cfg_write(2'd1, 16'h0600, 1'b1, 1'b0);
    cfg_write(2'd2, 16'h0600, 1'b1, 1'b0);
    now = 16'h0559;
    step(1);
    now = 16'h0600;
    expect_at(K_PEND, 16'h6, 1);
    expect_at(K_RING, 16'h1, 2);
    expect_at(K_ACT, 16'h1, 2);
    expect_at(K_PEND, 16'h4, 2);
    step(3);
    stop = 1'b1;
    expect_at(K_RING, 16'h0, 1);
    expect_at(K_STATE, 16'h0, 1);
    expect_at(K_PEND, 16'h4, 1);
    expect_at(K_RING, 16'h1, 2);
    expect_at(K_ACT, 16'h2, 2);
    expect_at(K_PEND, 16'h0, 2);
    step(1);
    stop = 1'b0;
    step(1);

    // Three snoozes allowed, the fourth is ignored
    snooze_round(16'h1200);
    snooze_round(16'h1300);
    snooze_round(16'h1500);
    snooze = 1'b1;
    expect_at(K_RING, 16'h1, 1);
    expect_at(K_STATE, 16'h1, 1);
    step(1);
    snooze = 1'b0;

    // Unanswered ring times out after RING_MIN minute events
    for (int i = 1; i <= 5; i++) begin
      now = 16'h1600 + 16'(i);
      expect_at(K_RING, (i == 5) ? 16'h0 : 16'h1, 1);
      expect_at(K_MISSED, (i == 5) ? 16'h1 : 16'h0, 1);
      step(1);
    end
    expect_at(K_STATE, 16'h0, 0);
    expect_at(K_MISSED, 16'h0, 1);
    step(1);

    // Rejected writes leave slot 0 at 07:30
    cfg_write(2'd0, 16'h2460, 1'b1, 1'b1);
    cfg_write(2'd0, 16'h2400, 1'b1, 1'b1);
    cfg_write(2'd0, 16'h1A00, 1'b1, 1'b1);
    cfg_write(2'd0, 16'h0760, 1'b1, 1'b1);
    cfg_write(2'd3, 16'h2359, 1'b0, 1'b0);
    now = 16'h1700;
    step(1);
    now = 16'h2460;
    expect_at(K_PEND, 16'h0, 1);
    step(1);
    now = 16'h0730;
    expect_at(K_PEND, 16'h1, 1);
    expect_at(K_RING, 16'h1, 2);
    expect_at(K_ACT, 16'h0, 2);
    step(3);
    stop   = 1'b1;
    snooze = 1'b1;
    expect_at(K_STATE, 16'h0, 1);
    expect_at(K_RING, 16'h0, 1);
    step(1);
    stop   = 1'b0;
    snooze = 1'b0;
    step(1);

    // Reset mid-ring with a pending backlog
    now = 16'h1700;
    step(1);
    now = 16'h0730;
    expect_at(K_RING, 16'h1, 2);
    step(3);
    now = 16'h0600;
    expect_at(K_PEND, 16'h6, 1);
    step(1);
    preset = 1'b1;
    now    = 16'h1200;
    expect_at(K_RING, 16'h0, 1);
    expect_at(K_PEND, 16'h0, 1);
    expect_at(K_STATE, 16'h0, 1);
    expect_at(K_ACT, 16'h0, 1);
    step(1);
    preset = 1'b0;
    step(1);
    cfg_write(2'd0, 16'h1200, 1'b1, 1'b0);
    expect_at(K_PEND, 16'h0, 0);
    now = 16'h0600;
    expect_at(K_PEND, 16'h0, 1);
    step(1);
    now = 16'h1200;
    expect_at(K_PEND, 16'h1, 1);
    expect_at(K_RING, 16'h1, 2);
    step(3);
    stop = 1'b1;
    expect_at(K_RING, 16'h0, 1);
    step(1);
    stop = 1'b0;
    step(4);

    n_vec++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d entries left, expected 0", sb.size());
    end
    n_vec++;
    if (n_missed_seen != 1) begin
      n_bad++;
      $display("FAIL missed_pulses: got %0d, expected 1", n_missed_seen);
    end
    n_vec++;
    if (n_err_seen != 4) begin
      n_bad++;
      $display("FAIL cfg_err_pulses: got %0d, expected 4", n_err_seen);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
